// File: rtl/pcu_fetch_q_if.sv
// Fetch-side bundle for pcu_fetch_q: redirect input, memory request/response, IF/ID output.
// master = the fetch unit, slave = its environment (branch unit, memory, IF/ID).
interface pcu_fetch_q_if #(
  parameter int unsigned XLEN = 32
);
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            resp_valid;
  logic [XLEN-1:0] resp_inst;
  logic            resp_ready;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_inst;

  modport master (
    input  redirect, redirect_pc, req_ready, resp_valid, resp_inst, if_ready,
    output req_valid, req_addr, resp_ready, if_valid, if_pc, if_inst
  );

  modport slave (
    output redirect, redirect_pc, req_ready, resp_valid, resp_inst, if_ready,
    input  req_valid, req_addr, resp_ready, if_valid, if_pc, if_inst
  );
endinterface

// File: rtl/pcu_fetch_q.sv
// Program counter unit with credit-limited in-order fetch queue and stale-response dropping.
// Optional PCU_MISALIGN_EN: misaligned redirect targets are flagged and fetch is held off.
module pcu_fetch_q #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h8000_0000,
  parameter int unsigned     INST_BYTES = 4,
  parameter int unsigned     DEPTH      = 4
) (
  input logic           clk,
  input logic           rst,
`ifdef PCU_MISALIGN_EN
  output logic          misalign,
`endif
  pcu_fetch_q_if.master bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;
  typedef logic [CntW:0]   cred_t;

  localparam ptr_t            PtrOne = ptr_t'(1);
  localparam cnt_t            CntOne = cnt_t'(1);
  localparam cred_t           CredMax = cred_t'(DEPTH);
  localparam logic [XLEN-1:0] PcStep = XLEN'(INST_BYTES);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q [DEPTH];
  ptr_t            pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
  cnt_t            pend_cnt_q, pend_cnt_d;
  logic [XLEN-1:0] buf_pc_q [DEPTH];
  logic [XLEN-1:0] buf_inst_q [DEPTH];
  ptr_t            buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
  cnt_t            buf_cnt_q, buf_cnt_d;
  cnt_t            kill_cnt_q, kill_cnt_d;

  logic  fetch_en, req_fire, resp_live, resp_kill, resp_keep, buf_pop;
  cred_t credits;

`ifdef PCU_MISALIGN_EN
  localparam logic [XLEN-1:0] AlignMask = XLEN'(INST_BYTES - 1);
  logic lock_q, lock_d, misalign_q, misalign_d;
  assign fetch_en = !lock_q;
  assign misalign = misalign_q;
`else
  assign fetch_en = 1'b1;
`endif

  // Every request in flight or entry held owns one slot, so responses never need backpressure.
  assign credits = cred_t'(pend_cnt_q) + cred_t'(kill_cnt_q) + cred_t'(buf_cnt_q);

  assign bus.req_valid  = !rst && !bus.redirect && fetch_en && (credits < CredMax);
  assign bus.req_addr   = pc_q;
  assign bus.resp_ready = 1'b1;
  assign bus.if_valid   = (buf_cnt_q != '0);
  assign bus.if_pc      = buf_pc_q[buf_rd_q];
  assign bus.if_inst    = buf_inst_q[buf_rd_q];

  assign req_fire  = bus.req_valid && bus.req_ready;
  // A response with nothing outstanding is a protocol error and is ignored entirely.
  assign resp_live = bus.resp_valid && ((kill_cnt_q != '0) || (pend_cnt_q != '0));
  assign resp_kill = resp_live && (kill_cnt_q != '0);
  assign resp_keep = resp_live && (kill_cnt_q == '0) && !bus.redirect;
  assign buf_pop   = bus.if_valid && bus.if_ready && !bus.redirect;

  always_comb begin
    pc_d       = pc_q;
    pend_wr_d  = pend_wr_q;
    pend_rd_d  = pend_rd_q;
    pend_cnt_d = pend_cnt_q;
    buf_wr_d   = buf_wr_q;
    buf_rd_d   = buf_rd_q;
    buf_cnt_d  = buf_cnt_q;
    kill_cnt_d = kill_cnt_q;
`ifdef PCU_MISALIGN_EN
    lock_d     = lock_q;
    misalign_d = 1'b0;
`endif
    if (bus.redirect) begin
      pc_d       = bus.redirect_pc;
      pend_wr_d  = '0;
      pend_rd_d  = '0;
      pend_cnt_d = '0;
      buf_wr_d   = '0;
      buf_rd_d   = '0;
      buf_cnt_d  = '0;
      // Live requests become stale; a response landing now is itself one of them.
      kill_cnt_d = kill_cnt_q + pend_cnt_q - cnt_t'(resp_live);
`ifdef PCU_MISALIGN_EN
      lock_d     = |(bus.redirect_pc & AlignMask);
      misalign_d = lock_d;
      if (lock_d) pc_d = bus.redirect_pc & ~AlignMask;
`endif
    end else begin
      if (req_fire) begin
        pc_d      = pc_q + PcStep;
        pend_wr_d = pend_wr_q + PtrOne;
      end
      if (resp_kill) kill_cnt_d = kill_cnt_q - CntOne;
      if (resp_keep) begin
        pend_rd_d = pend_rd_q + PtrOne;
        buf_wr_d  = buf_wr_q + PtrOne;
      end
      if (buf_pop) buf_rd_d = buf_rd_q + PtrOne;
      pend_cnt_d = pend_cnt_q + cnt_t'(req_fire) - cnt_t'(resp_keep);
      buf_cnt_d  = buf_cnt_q + cnt_t'(resp_keep) - cnt_t'(buf_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      pend_wr_q  <= '0;
      pend_rd_q  <= '0;
      pend_cnt_q <= '0;
      buf_wr_q   <= '0;
      buf_rd_q   <= '0;
      buf_cnt_q  <= '0;
      kill_cnt_q <= '0;
`ifdef PCU_MISALIGN_EN
      lock_q     <= 1'b0;
      misalign_q <= 1'b0;
`endif
    end else begin
      pc_q       <= pc_d;
      pend_wr_q  <= pend_wr_d;
      pend_rd_q  <= pend_rd_d;
      pend_cnt_q <= pend_cnt_d;
      buf_wr_q   <= buf_wr_d;
      buf_rd_q   <= buf_rd_d;
      buf_cnt_q  <= buf_cnt_d;
      kill_cnt_q <= kill_cnt_d;
`ifdef PCU_MISALIGN_EN
      lock_q     <= lock_d;
      misalign_q <= misalign_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && req_fire) pend_pc_q[pend_wr_q] <= pc_q;
    if (!rst && resp_keep) begin
      buf_pc_q[buf_wr_q]   <= pend_pc_q[pend_rd_q];
      buf_inst_q[buf_wr_q] <= bus.resp_inst;
    end
  end

endmodule
